mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 72 +++++++
 rtl/mem_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles every signal that the fetch, data and memory ports of
//   mem_port_arbiter exchange with the outside world.
//
//   Parameter
//     ADDR_W      byte address width of if_addr, d_addr and mem_addr
//
//   Fetch port   : if_req, if_addr        -> arbiter
//                  if_rdata, if_valid     <- arbiter
//   Data port    : d_req, d_we, d_func3, d_addr, d_wdata -> arbiter
//                  d_rdata, d_valid       <- arbiter
//   Memory port  : mem_req, mem_we, mem_func3, mem_addr, mem_wdata <- arbiter
//                  mem_rdata, mem_ack     -> arbiter
//   Pipeline     : stall                  <- arbiter
//
//   Modports
//     slave   the arbiter's view of the bundle
//     master  the environment's view (core + memory), the mirror of slave
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);

  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_valid;

  // data port
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_func3;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_valid;

  // shared memory port
  logic              mem_req;
  logic              mem_we;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  // pipeline freeze
  logic              stall;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_valid,
    input  d_req, d_we, d_func3, d_addr, d_wdata,
    output d_rdata, d_valid,
    output mem_req, mem_we, mem_func3, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output stall
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_valid,
    output d_req, d_we, d_func3, d_addr, d_wdata,
    input  d_rdata, d_valid,
    input  mem_req, mem_we, mem_func3, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  stall
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-outstanding memory port between an instruction-fetch
//   requester and a data (load/store) requester.
//
//   Ports
//     clk        single clock
//     rst        asynchronous reset, active low (0 = reset)
//     bus        mem_port_arbiter_if.slave: fetch port, data port, memory
//                port and the combinational stall output
//
//   Operation
//     Requests are only looked at in IDLE.  The winner's address, write
//     enable, width code and store data are captured into the mem_* output
//     registers, so everything the memory sees is registered and stays fixed
//     for the whole access regardless of what the requester does afterwards.
//     mem_req is held from the cycle after the grant up to and including the
//     cycle mem_ack is seen.  The requester's valid pulses the cycle after
//     mem_ack; that cycle never grants, leaving one idle bubble between
//     accesses.
//
//   Tie-break
//     MEM_ARB_ROUND_ROBIN_EN undefined : data port always wins a tie.
//     MEM_ARB_ROUND_ROBIN_EN defined   : on a tie, the port not granted last
//                                        wins; a lone requester always wins.
//
//   States
//     IDLE    | no access open; sample requests and grant
//     SRV_IF  | fetch access open on the memory port, waiting for mem_ack
//     SRV_D   | data access open on the memory port, waiting for mem_ack
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [2:0] FUNC3_LW = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SRV_IF = 2'd1,
    SRV_D  = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [2:0]        mem_func3_q, mem_func3_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q,  if_rdata_d;
  logic              if_valid_q,  if_valid_d;
  logic [31:0]       d_rdata_q,   d_rdata_d;
  logic              d_valid_q,   d_valid_d;

  logic              grant_any;
  logic              grant_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = data port received the most recent grant, 0 = fetch port
  logic              last_d_q,    last_d_d;
`endif

  // -------------------------------------------------------------------------
  // Arbitration.  The valid cycle is excluded: the requester that was just
  // served still shows its request in that cycle, and granting it again would
  // start a duplicate access.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_any = 1'b0;
    grant_d   = 1'b0;
    if ((state_q == IDLE) && !if_valid_q && !d_valid_q) begin
      grant_any = bus.if_req | bus.d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_d   = bus.d_req & (~bus.if_req | ~last_d_q);
`else
      grant_d   = bus.d_req;
`endif
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d_d = last_d_q;
    if (grant_any) begin
      last_d_d = grant_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Next-state and registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_func3_d = mem_func3_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // mem_ack seen here is spurious and deliberately ignored
        if (grant_any) begin
          mem_req_d = 1'b1;
          if (grant_d) begin
            state_d     = SRV_D;
            mem_we_d    = bus.d_we;
            mem_func3_d = bus.d_func3;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            state_d     = SRV_IF;
            mem_we_d    = 1'b0;
            mem_func3_d = FUNC3_LW;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = 32'd0;
          end
        end
      end

      SRV_IF: begin
        if (bus.mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_rdata_d = bus.mem_rdata;
          if_valid_d = 1'b1;
        end
      end

      SRV_D: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_valid_d = 1'b1;
          // a store returns no data; keep the last load result visible
          if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register.  Reset drops mem_req at once and wipes the valid
  // registers, so an access cut short by reset never reports completion.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_func3_q <= 3'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_func3_q <= mem_func3_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // after reset the fetch port counts as last granted, so the first tie
  // goes to the data port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_func3 = mem_func3_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;

  // freeze the pipeline while any requester is still waiting for its valid
  assign bus.stall = (bus.if_req & ~if_valid_q) | (bus.d_req & ~d_valid_q);

endmodule
